dmem_responder: RTL

Data-memory responder for the multicycle core: the target end of the load/store request issued by the memory-access stage. It accepts one word request at a time over a valid/ready handshake and holds it for a fixed, parameterised latency. It then commits the store or returns the load word, with a single-cycle response strobe. It replaces the zero-latency single-port RAM so that slower memory timing can be modelled without changing the core.

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency single-request data memory responder
// Optional out-of-range checking on upper address bits: DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem_q [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              c_write;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [ADDR_W-1:0] c_idx;
  logic              c_oor;
  logic [31:0]       c_rdata_d;

  assign accept = req_valid && ready_q;

  // With LATENCY==1 the commit happens on the accept edge itself, so the
  // live request is used there; every later commit uses the latched copy.
  always_comb begin
    c_write = write_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
  end

  assign enter_resp = (state_q == S_IDLE && accept && LATENCY == 1) ||
                      (state_q == S_WAIT && cnt_q == 4'd1);

  assign c_idx = c_addr[ADDR_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign c_oor = |c_addr[31:ADDR_W];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = |c_addr[31:ADDR_W];
  assign c_oor = 1'b0;
`endif

  assign c_rdata_d = c_oor ? 32'd0 : mem_q[c_idx];

  // Storage is deliberately outside the reset domain: reset never clears it.
  always_ff @(posedge clk) begin
    if (enter_resp && c_write && !c_oor) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (enter_resp) begin
        valid_q <= 1'b1;
        err_q   <= c_oor;
        if (!c_write) begin
          rdata_q <= c_rdata_d;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CNT_INIT;
            ready_q <= 1'b0;
            state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
